// File: rtl/deserializer_rst.sv
// deserializer_rst: serial-to-parallel receiver, LSB first, one bit per clock.
// Bits are qualified by i_valid and a frame must arrive with i_valid held
// continuously; a gap mid-frame aborts it with o_frame_err. Completed words go
// into a single-entry output register.
//
// Output handshake: o_data is offered while o_valid=1 and is taken on any
// rising edge where o_valid && i_ready. o_data is held stable until then.
// A word completing while the register is full and not being taken is
// dropped, and o_overflow pulses.
//
// Optional feature: define DESERIALIZER_PARITY_EN to append one even-parity
// bit to every frame. A bad frame is discarded and o_parity_err pulses.
module deserializer_rst #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overflow,
    output logic                  o_parity_err
);

`ifdef DESERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic                   frame_done;
    logic                   frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   word_ok;

    // Frame FSM state, bit counter and shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame FSM next state: capture bits, detect completion and truncation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_done  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    // Clear stale bits so a new frame never inherits old data.
                    shift_d    = '0;
                    shift_d[0] = i_data;
                    cnt_d      = CNT_W'(1);
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_valid) begin
                    shift_d[cnt_q] = i_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Gap inside a frame: drop the partial word.
                    cnt_d       = '0;
                    shift_d     = '0;
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DESERIALIZER_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Even parity across data bits and parity bit gates delivery
    always_comb begin
        word_ok      = frame_done && !(^shift_d);
        parity_err_d = frame_done && (^shift_d);
    end

    // Parity error pulse register
    always_ff @(posedge i_clk) begin
        if (i_rst) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end

    assign o_parity_err = parity_err_q;
`else
    // Without parity every completed frame is a candidate word
    always_comb begin
        word_ok = frame_done;
    end

    assign o_parity_err = 1'b0;
`endif

    // Output register next state: load, overflow drop or consume
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;
        if (word_ok) begin
            // A word being taken this cycle frees the slot for the new one.
            if (!valid_q || i_ready) begin
                data_d  = shift_d[DATA_WIDTH-1:0];
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register and overflow pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (cnt_q != '0);
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_deserializer_rst.sv
// Directed testbench for deserializer_rst (DATA_WIDTH=8). Inputs change 1ns
// after each rising edge; outputs are checked at that point, so they show the
// result of the edge just taken. Follows DESERIALIZER_PARITY_EN if defined.
module tb_deserializer_rst;

`ifdef DESERIALIZER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_data = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overflow;
    logic       o_parity_err;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    deserializer_rst #(.DATA_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .o_parity_err(o_parity_err)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Frame bit i of word w; bit 8 is the even-parity bit, optionally flipped.
    function automatic logic bit_of(input logic [7:0] w, input int i, input logic flip);
        if (i < 8) return w[i];
        return (^w) ^ flip;
    endfunction

    // Drive one complete frame; leaves i_valid high.
    task automatic send_word(input logic [7:0] w, input logic flip);
        for (int i = 0; i < FLEN; i++) begin
            i_valid = 1'b1;
            i_data  = bit_of(w, i, flip);
            tick();
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_data  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", o_data); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", o_frame_err); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", o_overflow); end
        total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b want=0", o_parity_err); end
        i_rst = 1'b0;
        tick();
    endtask

    // 0xA5 with i_ready=1: one-cycle o_valid, busy for FLEN-1 cycles
    task automatic test_basic();
        int busy_cycles = 0;
        int early_valid = 0;
        i_ready = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            i_valid = 1'b1;
            i_data  = bit_of(8'hA5, i, 1'b0);
            tick();
            if (o_busy === 1'b1) busy_cycles++;
            if (i < FLEN - 1 && o_valid !== 1'b0) early_valid++;
        end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", o_valid); end
        total++; if (o_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", o_data); end
        total++; if (early_valid !== 0) begin bad++; $display("FAIL basic_early_valid got=%0d want=0", early_valid); end
        total++; if (busy_cycles !== FLEN - 1) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cycles, FLEN - 1); end
        idle(1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", o_valid); end
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL basic_no_frame_err got=%b want=0", o_frame_err); end
        total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL basic_no_parity_err got=%b want=0", o_parity_err); end
        idle(1);
    endtask

    // Consumer stalled: second word is dropped, first one retained
    task automatic test_overflow();
        i_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_first_no_pulse got=%b want=0", o_overflow); end
        send_word(8'hC3, 1'b0);
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", o_overflow); end
        total++; if (o_data !== 8'h3C) begin bad++; $display("FAIL ovf_data_kept got=%h want=3c", o_data); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", o_valid); end
        idle(1);
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b want=0", o_overflow); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovf_still_valid got=%b want=1", o_valid); end
        i_ready = 1'b1;
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid got=%b want=0", o_valid); end
        total++; if (o_data !== 8'h3C) begin bad++; $display("FAIL ovf_drain_data got=%h want=3c", o_data); end
        idle(1);
    endtask

    // Frame truncated after 5 bits, then a good frame
    task automatic test_frame_err();
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 1'b1;
            tick();
        end
        idle(1);
        total++; if (o_frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b want=1", o_frame_err); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_valid got=%b want=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b want=0", o_busy); end
        idle(1);
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b want=0", o_frame_err); end
        send_word(8'h81, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ferr_next_valid got=%b want=1", o_valid); end
        total++; if (o_data !== 8'h81) begin bad++; $display("FAIL ferr_next_data got=%h want=81", o_data); end
        idle(2);
    endtask

    // Reset mid-frame with a word pending: both discarded, no error pulse
    task automatic test_reset_mid();
        i_ready = 1'b0;
        send_word(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_data  = 1'b1;
            tick();
        end
        i_rst   = 1'b1;
        i_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", o_busy); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", o_valid); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", o_data); end
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL rmid_frame_err got=%b want=0", o_frame_err); end
        tick();
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL rmid_frame_err_late got=%b want=0", o_frame_err); end
        i_ready = 1'b1;
        send_word(8'hFF, 1'b0);
        total++; if (o_data !== 8'hFF) begin bad++; $display("FAIL rmid_next_data got=%h want=ff", o_data); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_valid got=%b want=1", o_valid); end
        idle(2);
    endtask

    // Serializer-style loopback: continuous i_valid across two frames
    task automatic test_back_to_back();
        logic [7:0] words[2];
        int got = 0;
        int errs = 0;
        logic [7:0] exp_w;
        words[0] = 8'h5A;
        words[1] = 8'h12;
        exp_q.delete();
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h12);
        i_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                i_valid = 1'b1;
                i_data  = bit_of(words[f], i, 1'b0);
                tick();
                if (o_frame_err || o_overflow || o_parity_err) errs++;
                if (o_valid === 1'b1) begin
                    got++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b2b_extra_word got=%h want=none", o_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        total++;
                        if (o_data !== exp_w) begin bad++; $display("FAIL b2b_data got=%h want=%h", o_data, exp_w); end
                        total++;
                        if (i !== FLEN - 1) begin bad++; $display("FAIL b2b_latency got_bit=%0d want_bit=%0d", i, FLEN - 1); end
                    end
                end
            end
        end
        idle(1);
        if (o_frame_err || o_overflow || o_parity_err) errs++;
        total++; if (got !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
        total++; if (errs !== 0) begin bad++; $display("FAIL b2b_error_pulses got=%0d want=0", errs); end
        idle(1);
    endtask

`ifdef DESERIALIZER_PARITY_EN
    // 0x07 with correct parity (1) delivers; with parity 0 it is rejected
    task automatic test_parity();
        i_ready = 1'b1;
        send_word(8'h07, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL par_good_valid got=%b want=1", o_valid); end
        total++; if (o_data !== 8'h07) begin bad++; $display("FAIL par_good_data got=%h want=07", o_data); end
        total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL par_good_no_err got=%b want=0", o_parity_err); end
        idle(1);
        send_word(8'h07, 1'b1);
        total++; if (o_parity_err !== 1'b1) begin bad++; $display("FAIL par_bad_pulse got=%b want=1", o_parity_err); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL par_bad_no_valid got=%b want=0", o_valid); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL par_bad_no_ovf got=%b want=0", o_overflow); end
        idle(1);
        total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL par_one_cycle got=%b want=0", o_parity_err); end
        idle(1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
`ifdef DESERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
